// File: rtl/prog_sequencer.sv
// Program store and issue sequencer feeding 4-bit opcodes to the cpu core.
// state     | meaning
// IDLE      | nothing issued, program may be loaded
// RUN       | one opcode per clock from address 0 to the latched last address
// STEP_WAIT | one opcode issued per synchronised step_btn press
// DONE      | non-loop program finished, done held high
module prog_sequencer #(
    parameter int          AW          = 4,
    parameter logic [3:0]  IDLE_OPCODE = 4'b0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [3:0]    prog_wdata,
    input  logic [AW-1:0] prog_last,
    input  logic          start,
    input  logic          stop,
    input  logic          loop_en,
    input  logic          step_mode,
    input  logic          step_btn,
    output logic [3:0]    op_code,
    output logic          op_valid,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done
);
    typedef enum logic [1:0] {IDLE, RUN, STEP_WAIT, DONE} state_t;

    state_t        state, state_n;
    logic [3:0]    mem [2**AW];
    logic [AW-1:0] last_r, last_n;
    logic [AW-1:0] nxt_r, nxt_n;
    logic [AW-1:0] pc_n, pc_inc;
    logic          loop_r, loop_n;
    logic [3:0]    op_code_n;
    logic          op_valid_n, done_n;
    logic          btn_s1, btn_s2, btn_s3, step_pulse;
    logic          prog_ok;

    assign busy       = (state == RUN) || (state == STEP_WAIT);
    assign prog_ok    = (state == IDLE) || (state == DONE);
    assign pc_inc     = pc + AW'(1);
    assign step_pulse = btn_s2 & ~btn_s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= IDLE_OPCODE;
        end else if (prog_we && prog_ok) begin
            mem[prog_addr] <= prog_wdata;
        end
    end

    // btn_s1/btn_s2 resynchronise the raw button; btn_s3 is the edge-detect history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            btn_s3 <= 1'b0;
        end else begin
            btn_s1 <= step_btn;
            btn_s2 <= btn_s1;
            btn_s3 <= btn_s2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op_code  <= IDLE_OPCODE;
            op_valid <= 1'b0;
            pc       <= '0;
            done     <= 1'b0;
            last_r   <= '0;
            loop_r   <= 1'b0;
            nxt_r    <= '0;
        end else begin
            state    <= state_n;
            op_code  <= op_code_n;
            op_valid <= op_valid_n;
            pc       <= pc_n;
            done     <= done_n;
            last_r   <= last_n;
            loop_r   <= loop_n;
            nxt_r    <= nxt_n;
        end
    end

    always_comb begin
        state_n    = state;
        op_code_n  = op_code;
        op_valid_n = op_valid;
        pc_n       = pc;
        done_n     = done;
        last_n     = last_r;
        loop_n     = loop_r;
        nxt_n      = nxt_r;
        if (stop) begin
            state_n    = IDLE;
            op_code_n  = IDLE_OPCODE;
            op_valid_n = 1'b0;
            done_n     = 1'b0;
        end else if (start && !busy) begin
            last_n = prog_last;
            loop_n = loop_en;
            done_n = 1'b0;
            pc_n   = '0;
            if (step_mode) begin
                state_n    = STEP_WAIT;
                op_code_n  = IDLE_OPCODE;
                op_valid_n = 1'b0;
                nxt_n      = '0;
            end else begin
                state_n    = RUN;
                op_code_n  = mem[0];
                op_valid_n = 1'b1;
            end
        end else begin
            case (state)
                RUN: begin
                    if (pc != last_r) begin
                        pc_n      = pc_inc;
                        op_code_n = mem[pc_inc];
                    end else if (loop_r) begin
                        pc_n      = '0;
                        op_code_n = mem[0];
                    end else begin
                        state_n    = DONE;
                        op_code_n  = IDLE_OPCODE;
                        op_valid_n = 1'b0;
                        done_n     = 1'b1;
                    end
                end
                STEP_WAIT: begin
                    // op_valid marks the single issue cycle; press pulses landing in it are dropped
                    if (op_valid) begin
                        op_valid_n = 1'b0;
                        op_code_n  = IDLE_OPCODE;
                        if (pc == last_r && !loop_r) begin
                            state_n = DONE;
                            done_n  = 1'b1;
                        end else begin
                            nxt_n = (pc == last_r) ? '0 : pc_inc;
                        end
                    end else if (step_pulse) begin
                        op_code_n  = mem[nxt_r];
                        op_valid_n = 1'b1;
                        pc_n       = nxt_r;
                    end
                end
                DONE: begin
                    if (prog_we) done_n = 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: directed table, corner sequences, randomized runs.
module tb_prog_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [3:0] prog_wdata;
    logic [3:0] prog_last;
    logic       start;
    logic       stop;
    logic       loop_en;
    logic       step_mode;
    logic       step_btn;
    logic [3:0] op_code;
    logic       op_valid;
    logic [3:0] pc;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;
    logic [3:0] model_mem [16];

    typedef struct {
        logic [3:0] wdata;
        int         exp_op;
        int         exp_pc;
    } vec_t;
    vec_t vecs [8];

    prog_sequencer #(.AW(4), .IDLE_OPCODE(4'b0000)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .prog_last(prog_last), .start(start), .stop(stop),
        .loop_en(loop_en), .step_mode(step_mode), .step_btn(step_btn),
        .op_code(op_code), .op_valid(op_valid), .pc(pc), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_issue(input string nm, input int exp_op, input int exp_pc);
        chk({nm, "_op"}, int'(op_code), exp_op);
        chk({nm, "_valid"}, int'(op_valid), 1);
        chk({nm, "_pc"}, int'(pc), exp_pc);
    endtask

    task automatic chk_quiet(input string nm, input int exp_done);
        chk({nm, "_op"}, int'(op_code), 0);
        chk({nm, "_valid"}, int'(op_valid), 0);
        chk({nm, "_done"}, int'(done), exp_done);
        chk({nm, "_busy"}, int'(busy), 0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] d);
        prog_we    = 1'b1;
        prog_addr  = a;
        prog_wdata = d;
        @(negedge clk);
        prog_we    = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic go(input logic [3:0] last, input logic lp, input logic sm);
        prog_last = last;
        loop_en   = lp;
        step_mode = sm;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic press(input int k, input int exp_done);
        int seen = 0;
        int at   = -1;
        step_btn = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 5) step_btn = 1'b0;
            if (op_valid) begin
                seen++;
                at = c;
                chk_issue("step_issue", int'(model_mem[k]), k);
            end
        end
        chk("step_count", seen, 1);
        chk("step_latency", at, 3);
        chk("step_done", int'(done), exp_done);
    endtask

    initial begin
        logic [3:0] rlast;
        logic       rlp;
        int         n, ea;

        vecs[0] = '{4'b0001, 1, 0}; vecs[1] = '{4'b0110, 6, 1};
        vecs[2] = '{4'b0100, 4, 2}; vecs[3] = '{4'b0100, 4, 3};
        vecs[4] = '{4'b0100, 4, 4}; vecs[5] = '{4'b0011, 3, 5};
        vecs[6] = '{4'b1010, 10, 6}; vecs[7] = '{4'b0010, 2, 7};
        for (int i = 0; i < 16; i++) model_mem[i] = 4'b0000;

        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0; prog_last = '0;
        start = 1'b0; stop = 1'b0; loop_en = 1'b0; step_mode = 1'b0; step_btn = 1'b0;
        #1;
        chk_quiet("reset", 0);
        chk("reset_pc", int'(pc), 0);
        @(negedge clk);
        rst = 1'b0;

        // run-to-end with the directed program table
        for (int i = 0; i < 8; i++) wr(4'(i), vecs[i].wdata);
        go(4'd7, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk_issue("run", vecs[i].exp_op, vecs[i].exp_pc);
            @(negedge clk);
        end
        chk_quiet("run_end", 1);

        // loop mode: wrap without bubble, stop on the 12th opcode
        go(4'd7, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            chk_issue("loop", vecs[i % 8].exp_op, i % 8);
            if (i == 11) stop = 1'b1;
            @(negedge clk);
        end
        stop = 1'b0;
        chk_quiet("loop_stop", 0);
        chk("loop_stop_pc", int'(pc), 3);

        // single-step mode
        wr(4'd0, 4'b0001); wr(4'd1, 4'b0110); wr(4'd2, 4'b0011);
        go(4'd2, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("step_wait_op", int'(op_code), 0);
            chk("step_wait_valid", int'(op_valid), 0);
            chk("step_wait_busy", int'(busy), 1);
            @(negedge clk);
        end
        press(0, 0);
        press(1, 0);
        press(2, 1);

        // writes and start during RUN are ignored
        for (int i = 0; i < 8; i++) wr(4'(i), vecs[i].wdata);
        go(4'd7, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk_issue("midrun", vecs[i].exp_op, i);
            if (i == 2) begin
                prog_we = 1'b1; prog_addr = 4'd3; prog_wdata = 4'b1111; start = 1'b1;
            end else begin
                prog_we = 1'b0; start = 1'b0;
            end
            @(negedge clk);
        end
        chk_quiet("midrun_end", 1);
        go(4'd7, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk_issue("readback", vecs[i].exp_op, i);
            @(negedge clk);
        end

        // single-instruction program, restart from DONE
        wr(4'd0, 4'b0101);
        go(4'd0, 1'b0, 1'b0);
        chk_issue("single", 5, 0);
        @(negedge clk);
        chk_quiet("single_end", 1);
        go(4'd0, 1'b0, 1'b0);
        chk_issue("restart", 5, 0);
        chk("restart_done", int'(done), 0);
        @(negedge clk);
        chk("restart_end_done", int'(done), 1);

        // randomized runs against the reference model
        for (int t = 0; t < 10; t++) begin
            for (int a = 0; a < 16; a++) wr(4'(a), 4'($urandom_range(0, 15)));
            rlast = 4'($urandom_range(0, 15));
            rlp   = 1'($urandom_range(0, 1));
            go(rlast, rlp, 1'b0);
            n = rlp ? 2 * (int'(rlast) + 1) + 2 : int'(rlast) + 3;
            for (int i = 0; i < n; i++) begin
                if (rlp || i <= int'(rlast)) begin
                    ea = i % (int'(rlast) + 1);
                    chk_issue("rand", int'(model_mem[ea]), ea);
                end else begin
                    chk_quiet("rand_done", 1);
                    chk("rand_done_pc", int'(pc), int'(rlast));
                end
                @(negedge clk);
            end
            if (rlp) begin
                stop = 1'b1;
                @(negedge clk);
                stop = 1'b0;
                chk_quiet("rand_stop", 0);
            end
        end

        // asynchronous reset between edges mid-run
        go(4'd15, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_quiet("async_rst", 0);
        chk("async_rst_pc", int'(pc), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) model_mem[i] = 4'b0000;
        go(4'd3, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk_issue("post_rst", int'(model_mem[i]), i);
            @(negedge clk);
        end
        chk_quiet("post_rst_end", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Upstream instruction source for the cpu core: holds a small loadable program of 4-bit opcodes and issues one opcode per clock onto the core's op_code input.
- Replaces hand-driven op_code stimulus with an on-chip program store.
- Supports a run-to-end mode, a loop mode and a single-step mode driven by a push-button.

Parameters:
- AW, 4, program address width; depth = 2**AW entries.
- IDLE_OPCODE, 4'b0000, opcode driven whenever no instruction is being issued.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- prog_we  in  1  program write strobe.
- prog_addr  in  AW  program write address.
- prog_wdata  in  4  opcode to store.
- prog_last  in  AW  address of the last instruction; sampled at start.
- start  in  1  begin execution at address 0.
- stop  in  1  abort execution.
- loop_en  in  1  wrap from prog_last to 0 instead of finishing; sampled at start.
- step_mode  in  1  issue only on step_btn presses; sampled at start.
- step_btn  in  1  raw asynchronous push-button, active-high.
- op_code  out  4  opcode to the cpu core, registered.
- op_valid  out  1  op_code holds a program instruction this cycle.
- pc  out  AW  address of the instruction on op_code, or the last one issued.
- busy  out  1  state is RUN or STEP_WAIT.
- done  out  1  program completed (non-loop).

Behaviour:
- Reset (async): state IDLE, op_code = IDLE_OPCODE, op_valid = 0, pc = 0, busy = 0, done = 0. All memory entries are set to IDLE_OPCODE. Step synchroniser is cleared.
- Memory: 2**AW x 4, synchronous write. prog_we is accepted only in IDLE or DONE; it is ignored while busy. A write in DONE clears done.
- States: IDLE, RUN, STEP_WAIT, DONE. busy = (RUN or STEP_WAIT).
- Priority each edge: stop > start > normal advance.
- stop: in any state, next edge goes to IDLE with op_code = IDLE_OPCODE, op_valid = 0 and done = 0. pc holds its value.
- start in IDLE or DONE: next edge latches prog_last, loop_en and step_mode, and clears done.
  - step_mode = 0: go to RUN with pc = 0, op_code = mem[0], op_valid = 1.
  - step_mode = 1: go to STEP_WAIT with op_code = IDLE_OPCODE, op_valid = 0, and next issue address 0.
- start while busy is ignored.
- Latency: first opcode is visible one clock after the start edge. After that, one new opcode per clock, with no bubbles in RUN.
- RUN advance:
  - pc != last: pc <= pc+1, op_code <= mem[pc+1].
  - pc == last and loop: pc <= 0, op_code <= mem[0]. No bubble at the wrap.
  - pc == last and not loop: go to DONE, op_code = IDLE_OPCODE, op_valid = 0, done = 1. pc holds last.
- prog_last = 0 is legal: a single-instruction program.
- STEP_WAIT: outputs IDLE_OPCODE with op_valid = 0. A step pulse issues the next opcode for exactly one cycle (op_valid = 1, pc = issue address), then the block returns to STEP_WAIT. End-of-program and loop rules are the same as RUN, applied after the issued cycle: if non-loop and last was issued, go to DONE instead of STEP_WAIT.
- step_btn: 2-FF synchroniser followed by a rising-edge detector. One pulse per low-to-high transition, regardless of hold time. Pulses outside STEP_WAIT are discarded. Added latency is 3 clocks from the press to the opcode on op_code.
- DONE: done = 1 is held until start, stop, prog_we or rst.
- Reset mid-run: immediate return to reset values; program contents are lost.

Test Plan:
- Load 0001,0110,0100,0100,0100,0011,1010,0010 at addresses 0..7, prog_last = 7, loop_en = 0, start for 1 cycle.
  - Required: op_code shows exactly that sequence on 8 consecutive clocks with op_valid = 1 and pc = 0..7.
  - Then op_code = 0000, op_valid = 0, done = 1, busy = 0.
- Same program with loop_en = 1.
  - Required: after 0010 at pc = 7 the next clock shows 0001 at pc = 0, no bubble.
  - Assert stop on the 12th opcode: next clock op_code = 0000, state IDLE, done = 0.
- step_mode = 1, prog_last = 2, program 0001,0110,0011.
  - Required: op_code stays 0000 until a press.
  - Each press held 5 clocks yields exactly one op_valid cycle, 3 clocks after the press.
  - Third press leads to done = 1.
- Mid-RUN: prog_we to address 3 and start asserted.
  - Required: both ignored; the sequence is unchanged and memory readback after DONE shows the original value.
- prog_last = 0, program 0101.
  - Required: one cycle of 0101, then DONE.
  - start again in DONE: 0101 reissued one clock later, done cleared.
- rst asserted asynchronously between clock edges mid-RUN.
  - Required: op_code = 0000, op_valid = 0, pc = 0 immediately.
  - A following start with no reload issues 0000 instructions with op_valid = 1.
